// File: rtl/axi4_join_buf.sv
// ---------------------------------------------------------------------------
// axi4_join_buf
//   Joins a write-only AXI4 master (AW/W/B) and a read-only AXI4 master
//   (AR/R) onto one AXI4 slave port.
//   - AW, W and AR can go through 2-entry skid slices (REG_REQ=1) or
//     straight through as wires (REG_REQ=0).
//   - B and R always pass straight through.
//   - Each direction has its own limit on outstanding bursts.
//     The write count goes up on an AW handshake and down on a B
//     handshake. The read count goes up on an AR handshake and down on
//     an R handshake with rlast set.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   inport_wr_aw* / w* / b*  write master side
//   inport_rd_ar* / r*       read master side
//   outport_{aw,w,b,ar,r}*   slave side
//   wr_outstanding_o         current write burst count
//   rd_outstanding_o         current read burst count
//   idle_o                   both counts are zero and every slice is empty
// ---------------------------------------------------------------------------

// Request-channel slice.
//   REG=1: output register plus skid register. Accepted beats appear on
//          the output one cycle later. in_ready_o depends only on
//          registers, so there is no combinational path from out_ready_i.
//   REG=0: plain wires. Ready and valid are held low until the
//          post-reset run flag is set.
module axi4_join_buf_slice #(
    parameter int W   = 8,
    parameter bit REG = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         run_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         empty_o
);
    if (REG) begin : g_reg
        logic         out_valid_q;
        logic         skid_valid_q;
        logic [W-1:0] out_data_q;
        logic [W-1:0] skid_data_q;
        logic         in_hs;

        assign in_ready_o  = run_i & ~skid_valid_q;
        assign in_hs       = in_valid_i & in_ready_o;
        assign out_valid_o = out_valid_q;
        assign out_data_o  = out_data_q;
        assign empty_o     = ~out_valid_q & ~skid_valid_q;

        // NOTE: registers are updated with non-blocking assignments. Every
        // read in this block then sees the value from before the clock
        // edge, whatever order the statements are written in.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
                out_data_q   <= '0;
                skid_data_q  <= '0;
            end else if (out_valid_q && !out_ready_i) begin
                // Output is stalled. A beat accepted this cycle goes to the skid register.
                if (in_hs) begin
                    skid_valid_q <= 1'b1;
                    skid_data_q  <= in_data_i;
                end
            end else if (skid_valid_q) begin
                // Move the skid beat to the output first. in_ready_o is low
                // this cycle, so no new beat can arrive.
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_hs;
                if (in_hs) begin
                    out_data_q <= in_data_i;
                end
            end
        end
    end else begin : g_wire
        assign in_ready_o  = run_i & out_ready_i;
        assign out_valid_o = run_i & in_valid_i;
        assign out_data_o  = in_data_i;
        assign empty_o     = 1'b1;
    end
endmodule

module axi4_join_buf #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int REG_REQ = 1,
    parameter int MAX_WR  = 4,
    parameter int MAX_RD  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // write master
    input  logic                inport_wr_awvalid_i,
    output logic                inport_wr_awready_o,
    input  logic [ADDR_W-1:0]   inport_wr_awaddr_i,
    input  logic [ID_W-1:0]     inport_wr_awid_i,
    input  logic [7:0]          inport_wr_awlen_i,
    input  logic [1:0]          inport_wr_awburst_i,
    input  logic                inport_wr_wvalid_i,
    output logic                inport_wr_wready_o,
    input  logic [DATA_W-1:0]   inport_wr_wdata_i,
    input  logic [DATA_W/8-1:0] inport_wr_wstrb_i,
    input  logic                inport_wr_wlast_i,
    output logic                inport_wr_bvalid_o,
    input  logic                inport_wr_bready_i,
    output logic [1:0]          inport_wr_bresp_o,
    output logic [ID_W-1:0]     inport_wr_bid_o,
    // read master
    input  logic                inport_rd_arvalid_i,
    output logic                inport_rd_arready_o,
    input  logic [ADDR_W-1:0]   inport_rd_araddr_i,
    input  logic [ID_W-1:0]     inport_rd_arid_i,
    input  logic [7:0]          inport_rd_arlen_i,
    input  logic [1:0]          inport_rd_arburst_i,
    output logic                inport_rd_rvalid_o,
    input  logic                inport_rd_rready_i,
    output logic [DATA_W-1:0]   inport_rd_rdata_o,
    output logic [1:0]          inport_rd_rresp_o,
    output logic [ID_W-1:0]     inport_rd_rid_o,
    output logic                inport_rd_rlast_o,
    // slave
    output logic                outport_awvalid_o,
    input  logic                outport_awready_i,
    output logic [ADDR_W-1:0]   outport_awaddr_o,
    output logic [ID_W-1:0]     outport_awid_o,
    output logic [7:0]          outport_awlen_o,
    output logic [1:0]          outport_awburst_o,
    output logic                outport_wvalid_o,
    input  logic                outport_wready_i,
    output logic [DATA_W-1:0]   outport_wdata_o,
    output logic [DATA_W/8-1:0] outport_wstrb_o,
    output logic                outport_wlast_o,
    input  logic                outport_bvalid_i,
    output logic                outport_bready_o,
    input  logic [1:0]          outport_bresp_i,
    input  logic [ID_W-1:0]     outport_bid_i,
    output logic                outport_arvalid_o,
    input  logic                outport_arready_i,
    output logic [ADDR_W-1:0]   outport_araddr_o,
    output logic [ID_W-1:0]     outport_arid_o,
    output logic [7:0]          outport_arlen_o,
    output logic [1:0]          outport_arburst_o,
    input  logic                outport_rvalid_i,
    output logic                outport_rready_o,
    input  logic [DATA_W-1:0]   outport_rdata_i,
    input  logic [1:0]          outport_rresp_i,
    input  logic [ID_W-1:0]     outport_rid_i,
    input  logic                outport_rlast_i,
    // status
    output logic [7:0]          wr_outstanding_o,
    output logic [7:0]          rd_outstanding_o,
    output logic                idle_o
);
    localparam int         A_PW     = ADDR_W + ID_W + 8 + 2;
    localparam int         W_PW     = DATA_W + DATA_W / 8 + 1;
    localparam logic [7:0] MAX_WR_C = 8'(MAX_WR);
    localparam logic [7:0] MAX_RD_C = 8'(MAX_RD);

    logic       run_q;
    logic [7:0] wr_cnt_q, rd_cnt_q;
    logic       b_hs, r_last_hs, aw_hs, ar_hs;
    logic       wr_block, rd_block;
    logic       aw_ready, ar_ready;
    logic       aw_empty, w_empty, ar_empty;

    // Goes high on the first clock edge after reset is released. Until then
    // every request ready and every wire-mode valid is held low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) run_q <= 1'b0;
        else         run_q <= 1'b1;
    end

    // B and R pass straight through.
    assign inport_wr_bvalid_o = outport_bvalid_i;
    assign inport_wr_bresp_o  = outport_bresp_i;
    assign inport_wr_bid_o    = outport_bid_i;
    assign outport_bready_o   = inport_wr_bready_i;
    assign inport_rd_rvalid_o = outport_rvalid_i;
    assign inport_rd_rdata_o  = outport_rdata_i;
    assign inport_rd_rresp_o  = outport_rresp_i;
    assign inport_rd_rid_o    = outport_rid_i;
    assign inport_rd_rlast_o  = outport_rlast_i;
    assign outport_rready_o   = inport_rd_rready_i;

    assign b_hs      = outport_bvalid_i & inport_wr_bready_i;
    assign r_last_hs = outport_rvalid_i & inport_rd_rready_i & outport_rlast_i;

    // A completion in the current cycle frees a slot in that same cycle.
    // This lets a request waiting at the limit go through at once.
    assign wr_block = (wr_cnt_q == MAX_WR_C) & ~b_hs;
    assign rd_block = (rd_cnt_q == MAX_RD_C) & ~r_last_hs;

    assign inport_wr_awready_o = aw_ready & ~wr_block;
    assign inport_rd_arready_o = ar_ready & ~rd_block;
    assign aw_hs = inport_wr_awvalid_i & inport_wr_awready_o;
    assign ar_hs = inport_rd_arvalid_i & inport_rd_arready_o;

    function automatic logic [7:0] cnt_next(logic [7:0] cnt, logic inc, logic dec);
        if (inc && !dec)               return cnt + 8'd1;
        else if (dec && !inc && cnt != 8'd0) return cnt - 8'd1;
        else                           return cnt;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q <= 8'd0;
            rd_cnt_q <= 8'd0;
        end else begin
            wr_cnt_q <= cnt_next(wr_cnt_q, aw_hs, b_hs);
            rd_cnt_q <= cnt_next(rd_cnt_q, ar_hs, r_last_hs);
        end
    end

    axi4_join_buf_slice #(.W(A_PW), .REG(REG_REQ != 0)) u_aw (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_q),
        .in_valid_i  (inport_wr_awvalid_i & ~wr_block),
        .in_ready_o  (aw_ready),
        .in_data_i   ({inport_wr_awaddr_i, inport_wr_awid_i, inport_wr_awlen_i, inport_wr_awburst_i}),
        .out_valid_o (outport_awvalid_o),
        .out_ready_i (outport_awready_i),
        .out_data_o  ({outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o}),
        .empty_o     (aw_empty)
    );

    axi4_join_buf_slice #(.W(W_PW), .REG(REG_REQ != 0)) u_w (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_q),
        .in_valid_i  (inport_wr_wvalid_i),
        .in_ready_o  (inport_wr_wready_o),
        .in_data_i   ({inport_wr_wdata_i, inport_wr_wstrb_i, inport_wr_wlast_i}),
        .out_valid_o (outport_wvalid_o),
        .out_ready_i (outport_wready_i),
        .out_data_o  ({outport_wdata_o, outport_wstrb_o, outport_wlast_o}),
        .empty_o     (w_empty)
    );

    axi4_join_buf_slice #(.W(A_PW), .REG(REG_REQ != 0)) u_ar (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_q),
        .in_valid_i  (inport_rd_arvalid_i & ~rd_block),
        .in_ready_o  (ar_ready),
        .in_data_i   ({inport_rd_araddr_i, inport_rd_arid_i, inport_rd_arlen_i, inport_rd_arburst_i}),
        .out_valid_o (outport_arvalid_o),
        .out_ready_i (outport_arready_i),
        .out_data_o  ({outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o}),
        .empty_o     (ar_empty)
    );

    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;
    assign idle_o = (wr_cnt_q == 8'd0) & (rd_cnt_q == 8'd0) & aw_empty & w_empty & ar_empty;
endmodule

// File: tb/tb_axi4_join_buf.sv
module tb_axi4_join_buf;
    logic        clk_i = 1'b0;
    logic        rst_ni;

    // shared stimulus (drives both instances)
    logic        aw_valid, aw_rdy_s;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        w_valid, w_rdy_s, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid_s, b_rdy;
    logic [1:0]  b_resp_s;
    logic [3:0]  b_id_s;
    logic        ar_valid, ar_rdy_s;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic        r_valid_s, r_rdy, r_last_s;
    logic [31:0] r_data_s;
    logic [1:0]  r_resp_s;
    logic [3:0]  r_id_s;

    // outputs of the registered instance
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [3:0]  bid, rid;
    logic [31:0] rdata;
    logic        o_awvalid, o_wvalid, o_wlast, o_bready, o_arvalid, o_rready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [3:0]  o_awid, o_arid, o_wstrb;
    logic [7:0]  o_awlen, o_arlen;
    logic [1:0]  o_awburst, o_arburst;
    logic [7:0]  wr_out, rd_out;
    logic        idle;

    // outputs of the wire-mode instance
    logic        z_awready, z_wready, z_bvalid, z_arready, z_rvalid, z_rlast;
    logic [1:0]  z_bresp, z_rresp;
    logic [3:0]  z_bid, z_rid;
    logic [31:0] z_rdata;
    logic        z_awvalid, z_wvalid, z_wlast, z_bready, z_arvalid, z_rready;
    logic [31:0] z_awaddr, z_wdata, z_araddr;
    logic [3:0]  z_awid, z_arid, z_wstrb;
    logic [7:0]  z_awlen, z_arlen;
    logic [1:0]  z_awburst, z_arburst;
    logic [7:0]  z_wr_out, z_rd_out;
    logic        z_idle;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    axi4_join_buf #(.REG_REQ(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inport_wr_awvalid_i(aw_valid), .inport_wr_awready_o(awready), .inport_wr_awaddr_i(aw_addr),
        .inport_wr_awid_i(aw_id), .inport_wr_awlen_i(aw_len), .inport_wr_awburst_i(aw_burst),
        .inport_wr_wvalid_i(w_valid), .inport_wr_wready_o(wready), .inport_wr_wdata_i(w_data),
        .inport_wr_wstrb_i(w_strb), .inport_wr_wlast_i(w_last),
        .inport_wr_bvalid_o(bvalid), .inport_wr_bready_i(b_rdy), .inport_wr_bresp_o(bresp), .inport_wr_bid_o(bid),
        .inport_rd_arvalid_i(ar_valid), .inport_rd_arready_o(arready), .inport_rd_araddr_i(ar_addr),
        .inport_rd_arid_i(ar_id), .inport_rd_arlen_i(ar_len), .inport_rd_arburst_i(ar_burst),
        .inport_rd_rvalid_o(rvalid), .inport_rd_rready_i(r_rdy), .inport_rd_rdata_o(rdata),
        .inport_rd_rresp_o(rresp), .inport_rd_rid_o(rid), .inport_rd_rlast_o(rlast),
        .outport_awvalid_o(o_awvalid), .outport_awready_i(aw_rdy_s), .outport_awaddr_o(o_awaddr),
        .outport_awid_o(o_awid), .outport_awlen_o(o_awlen), .outport_awburst_o(o_awburst),
        .outport_wvalid_o(o_wvalid), .outport_wready_i(w_rdy_s), .outport_wdata_o(o_wdata),
        .outport_wstrb_o(o_wstrb), .outport_wlast_o(o_wlast),
        .outport_bvalid_i(b_valid_s), .outport_bready_o(o_bready), .outport_bresp_i(b_resp_s), .outport_bid_i(b_id_s),
        .outport_arvalid_o(o_arvalid), .outport_arready_i(ar_rdy_s), .outport_araddr_o(o_araddr),
        .outport_arid_o(o_arid), .outport_arlen_o(o_arlen), .outport_arburst_o(o_arburst),
        .outport_rvalid_i(r_valid_s), .outport_rready_o(o_rready), .outport_rdata_i(r_data_s),
        .outport_rresp_i(r_resp_s), .outport_rid_i(r_id_s), .outport_rlast_i(r_last_s),
        .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out), .idle_o(idle)
    );

    axi4_join_buf #(.REG_REQ(0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inport_wr_awvalid_i(aw_valid), .inport_wr_awready_o(z_awready), .inport_wr_awaddr_i(aw_addr),
        .inport_wr_awid_i(aw_id), .inport_wr_awlen_i(aw_len), .inport_wr_awburst_i(aw_burst),
        .inport_wr_wvalid_i(w_valid), .inport_wr_wready_o(z_wready), .inport_wr_wdata_i(w_data),
        .inport_wr_wstrb_i(w_strb), .inport_wr_wlast_i(w_last),
        .inport_wr_bvalid_o(z_bvalid), .inport_wr_bready_i(b_rdy), .inport_wr_bresp_o(z_bresp), .inport_wr_bid_o(z_bid),
        .inport_rd_arvalid_i(ar_valid), .inport_rd_arready_o(z_arready), .inport_rd_araddr_i(ar_addr),
        .inport_rd_arid_i(ar_id), .inport_rd_arlen_i(ar_len), .inport_rd_arburst_i(ar_burst),
        .inport_rd_rvalid_o(z_rvalid), .inport_rd_rready_i(r_rdy), .inport_rd_rdata_o(z_rdata),
        .inport_rd_rresp_o(z_rresp), .inport_rd_rid_o(z_rid), .inport_rd_rlast_o(z_rlast),
        .outport_awvalid_o(z_awvalid), .outport_awready_i(aw_rdy_s), .outport_awaddr_o(z_awaddr),
        .outport_awid_o(z_awid), .outport_awlen_o(z_awlen), .outport_awburst_o(z_awburst),
        .outport_wvalid_o(z_wvalid), .outport_wready_i(w_rdy_s), .outport_wdata_o(z_wdata),
        .outport_wstrb_o(z_wstrb), .outport_wlast_o(z_wlast),
        .outport_bvalid_i(b_valid_s), .outport_bready_o(z_bready), .outport_bresp_i(b_resp_s), .outport_bid_i(b_id_s),
        .outport_arvalid_o(z_arvalid), .outport_arready_i(ar_rdy_s), .outport_araddr_o(z_araddr),
        .outport_arid_o(z_arid), .outport_arlen_o(z_arlen), .outport_arburst_o(z_arburst),
        .outport_rvalid_i(r_valid_s), .outport_rready_o(z_rready), .outport_rdata_i(r_data_s),
        .outport_rresp_i(r_resp_s), .outport_rid_i(r_id_s), .outport_rlast_i(r_last_s),
        .wr_outstanding_o(z_wr_out), .rd_outstanding_o(z_rd_out), .idle_o(z_idle)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks happen at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int send, recv, gaps, cyc;
        rst_ni = 1'b0;
        aw_valid = 0; aw_rdy_s = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_burst = 0;
        w_valid = 0; w_rdy_s = 0; w_last = 0; w_data = 0; w_strb = 4'hF;
        b_valid_s = 0; b_rdy = 0; b_resp_s = 0; b_id_s = 0;
        ar_valid = 0; ar_rdy_s = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_burst = 0;
        r_valid_s = 0; r_rdy = 0; r_last_s = 0; r_data_s = 0; r_resp_s = 0; r_id_s = 0;

        // reset state
        #4;
        check("rst_idle", idle, 1);
        check("rst_wr_cnt", wr_out, 0);
        check("rst_rd_cnt", rd_out, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_awvalid", o_awvalid, 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // 1: single read burst through the AR slice
        ar_valid = 1; ar_addr = 32'h1000; ar_len = 8'd3; ar_id = 4'd2; ar_burst = 2'd1; ar_rdy_s = 1;
        #4;
        check("t1_arready", arready, 1);
        check("t1_arvalid_same", o_arvalid, 0);
        tick();
        ar_valid = 0;
        #4;
        check("t1_arvalid", o_arvalid, 1);
        check("t1_araddr", o_araddr, 32'h1000);
        check("t1_arlen", o_arlen, 3);
        check("t1_rd_cnt1", rd_out, 1);
        check("t1_not_idle", idle, 0);
        tick();
        #4;
        check("t1_arvalid_drained", o_arvalid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            r_valid_s = 1; r_rdy = 1; r_data_s = 32'hA0 + i; r_last_s = (i == 3); r_id_s = 4'd2;
            #4;
            check("t1_rdata", rdata, 32'hA0 + i);
            check("t1_rd_cnt_mid", rd_out, 1);
            tick();
        end
        r_valid_s = 0; r_last_s = 0;
        #4;
        check("t1_rd_cnt0", rd_out, 0);
        check("t1_idle", idle, 1);
        tick();

        // 2: write limit at 4
        aw_rdy_s = 1; b_rdy = 1; aw_valid = 1; aw_len = 0;
        for (int i = 0; i < 4; i++) begin
            aw_addr = 32'h100 * i;
            #4;
            check("t2_awready", awready, 1);
            tick();
        end
        aw_addr = 32'h400;
        #4;
        check("t2_aw_full", awready, 0);
        check("t2_wr_cnt4", wr_out, 4);
        tick();
        b_valid_s = 1; b_id_s = 4'd7; b_resp_s = 2'd0;
        #4;
        check("t2_aw_freed", awready, 1);
        check("t2_bvalid", bvalid, 1);
        check("t2_bid", bid, 7);
        tick();
        aw_valid = 0; b_valid_s = 0;
        #4;
        check("t2_wr_cnt_stays", wr_out, 4);
        tick();
        b_valid_s = 1;
        for (int i = 0; i < 4; i++) tick();
        b_valid_s = 0;
        #4;
        check("t2_wr_cnt_drained", wr_out, 0);
        tick();

        // 3: W streaming, slave ready toggling every cycle
        send = 0; recv = 0; gaps = 0; cyc = 0;
        w_rdy_s = 0;
        while (recv < 16 && cyc < 200) begin
            w_rdy_s = ~w_rdy_s;
            w_valid = (send < 16);
            w_data  = send;
            w_last  = (send % 4 == 3);
            #4;
            if (w_rdy_s && o_wvalid) begin
                check("t3_wdata", o_wdata, recv);
                recv++;
            end else if (w_rdy_s && recv > 0) begin
                gaps++;
            end
            if (w_valid && wready) send++;
            tick();
            cyc++;
        end
        check("t3_all_beats", recv, 16);
        check("t3_no_gaps", gaps, 0);
        w_valid = 0; w_rdy_s = 1;
        tick();

        // 4: AR and last-R handshakes in the same cycle
        ar_valid = 1; ar_rdy_s = 1; ar_len = 0;
        tick(); tick();
        ar_valid = 0;
        #4;
        check("t4_rd_cnt2", rd_out, 2);
        tick();
        ar_valid = 1; r_valid_s = 1; r_last_s = 1; r_rdy = 1;
        #4;
        check("t4_arready", arready, 1);
        tick();
        ar_valid = 0; r_valid_s = 0; r_last_s = 0;
        #4;
        check("t4_rd_cnt_same", rd_out, 2);
        tick();
        r_valid_s = 1; r_last_s = 1;
        tick(); tick();
        r_valid_s = 0; r_last_s = 0;
        #4;
        check("t4_rd_cnt0", rd_out, 0);
        tick();

        // 5: reset arrives during the third beat of a W burst
        aw_valid = 1; aw_rdy_s = 1;
        tick();
        aw_valid = 0; w_rdy_s = 1;
        for (int i = 0; i < 2; i++) begin
            w_valid = 1; w_data = 32'h50 + i; w_last = 0;
            tick();
        end
        w_data = 32'h52;
        #1;
        check("t5_wvalid_before", o_wvalid, 1);
        check("t5_wr_cnt_before", wr_out, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t5_wvalid_async", o_wvalid, 0);
        check("t5_awvalid_async", o_awvalid, 0);
        check("t5_wready_rst", wready, 0);
        check("t5_wr_cnt_rst", wr_out, 0);
        w_valid = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        #4;
        check("t5_idle_after", idle, 1);
        check("t5_wr_cnt_after", wr_out, 0);
        check("t5_wready_after", wready, 1);
        tick();

        // 6: wire-mode instance, AW and AR in the same cycle
        aw_valid = 1; aw_addr = 32'hDEAD0000; aw_id = 4'd5; aw_len = 8'd7; aw_burst = 2'd1; aw_rdy_s = 1;
        ar_valid = 1; ar_addr = 32'hBEEF0040; ar_id = 4'd9; ar_len = 8'd15; ar_burst = 2'd2; ar_rdy_s = 1;
        #4;
        check("t6_awvalid", z_awvalid, 1);
        check("t6_awaddr", z_awaddr, 32'hDEAD0000);
        check("t6_awid", z_awid, 5);
        check("t6_awlen", z_awlen, 7);
        check("t6_arvalid", z_arvalid, 1);
        check("t6_araddr", z_araddr, 32'hBEEF0040);
        check("t6_arid", z_arid, 9);
        check("t6_arburst", z_arburst, 2);
        check("t6_awready", z_awready, 1);
        check("t6_arready", z_arready, 1);
        check("t6_reg_latency", o_awvalid, 0);
        tick();
        aw_valid = 0; ar_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
